// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: fetches 32-bit instructions as four little-endian byte reads into the IR, with redirect, valid/ready handoff and a sticky timeout error
module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  ir_data,
  output logic [3:0]  ir_byte_we,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_pc,
  output logic        fetch_err
);
  typedef enum logic [2:0] {IDLE, REQ, LAST, VALID, ERR} state_t;
  state_t      state;
  logic [31:0] pc;
  logic [31:0] wait_cnt;
  logic [1:0]  byte_cnt;
  logic [31:0] redir_pc;
  logic [31:0] next_pc;
  assign redir_pc = {redirect_pc[31:2], 2'b00};
  assign next_pc  = pc + 32'd4;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      wait_cnt   <= '0;
      byte_cnt   <= '0;
      mem_rd     <= 1'b0;
      mem_addr   <= RESET_PC;
      ir_data    <= '0;
      ir_byte_we <= '0;
      inst_valid <= 1'b0;
      inst_pc    <= RESET_PC;
      fetch_err  <= 1'b0;
    end else begin
      ir_byte_we <= '0;
      if (redirect_valid) begin
        pc         <= redir_pc;
        inst_pc    <= redir_pc;
        byte_cnt   <= '0;
        wait_cnt   <= '0;
        inst_valid <= 1'b0;
        fetch_err  <= 1'b0;
        mem_rd     <= fetch_en;
        mem_addr   <= redir_pc;
        state      <= fetch_en ? REQ : IDLE;
      end else
        case (state)
          IDLE:
            if (fetch_en) begin
              state    <= REQ;
              mem_rd   <= 1'b1;
              mem_addr <= pc;
            end
          REQ:
            if (!mem_rd)
              mem_rd <= 1'b1;
            else if (mem_ack) begin
              ir_data    <= mem_rdata;
              ir_byte_we <= 4'b0001 << byte_cnt;
              byte_cnt   <= byte_cnt + 2'd1;
              wait_cnt   <= '0;
              mem_rd     <= 1'b0;
              mem_addr   <= pc + {30'd0, 2'(byte_cnt + 2'd1)};
              if (byte_cnt == 2'd3)
                state <= LAST;
            end else if (TIMEOUT != 0 && wait_cnt == 32'(TIMEOUT - 1)) begin
              state     <= ERR;
              fetch_err <= 1'b1;
              mem_rd    <= 1'b0;
            end else
              wait_cnt <= wait_cnt + 32'd1;
          LAST: begin
            state      <= VALID;
            inst_valid <= 1'b1;
          end
          VALID:
            if (inst_ready) begin
              inst_valid <= 1'b0;
              pc         <= next_pc;
              inst_pc    <= next_pc;
              mem_addr   <= next_pc;
              mem_rd     <= fetch_en;
              state      <= fetch_en ? REQ : IDLE;
            end
          default: ;
        endcase
    end
endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// tb_inst_fetch_ctrl: vector table, directed corner sequences and randomized traffic against a transaction-level fetch model
module tb_inst_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = '0;
  logic        inst_ready = 1'b0;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic [7:0]  ir_data;
  logic [3:0]  ir_byte_we;
  logic        inst_valid;
  logic [31:0] inst_pc;
  logic        fetch_err;
  always #5 clk = ~clk;
  inst_fetch_ctrl #(.RESET_PC(32'h0), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .ir_data(ir_data), .ir_byte_we(ir_byte_we), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst_pc(inst_pc), .fetch_err(fetch_err)
  );
  int checks = 0;
  int errors = 0;
  logic [31:0] m_pc, tb_ir;
  int m_cnt, m_wait, wait_n, lat, accepted;
  bit pend, exp_valid, exp_err, no_ack, rd_seen;
  logic [3:0] exp_we;
  logic [7:0] exp_data;
  typedef struct {
    logic fe, ack, rdy;
    logic [7:0] rd;
    logic xrd;
    logic [31:0] xaddr;
    logic [3:0] xwe;
    logic [7:0] xd;
    logic [31:0] xpc;
    logic xv;
  } vec_t;
  vec_t tv[11];
  function automatic logic [7:0] memb(input logic [31:0] a);
    return 8'((a[1:0] + 3'd1) * 8'h11) ^ 8'(a[9:2] * 8'd7);
  endfunction
  function automatic logic [31:0] word(input logic [31:0] a);
    return {memb(a + 32'd3), memb(a + 32'd2), memb(a + 32'd1), memb(a)};
  endfunction
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic do_reset();
    #2;
    rst_n = 1'b0; fetch_en = 0; redirect_valid = 0; inst_ready = 0; mem_ack = 0; no_ack = 0;
    #1;
    chk("reset_outputs", {mem_rd, mem_addr, ir_data, ir_byte_we, inst_valid, inst_pc, fetch_err},
        {1'b0, 32'h0, 8'h0, 4'h0, 1'b0, 32'h0, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
    m_pc = 0; m_cnt = 0; m_wait = 0; pend = 0; exp_valid = 0; exp_err = 0; wait_n = lat; tb_ir = 0;
  endtask
  task automatic tick();
    logic p_rd, p_ack, p_redir, p_acc;
    logic [7:0] p_data;
    logic [31:0] p_rpc;
    p_rd = mem_rd; p_ack = mem_ack; p_redir = redirect_valid; p_acc = inst_valid && inst_ready;
    p_data = mem_rdata; p_rpc = redirect_pc;
    @(posedge clk);
    @(negedge clk);
    exp_we = 0;
    if (p_redir) begin
      m_pc = {p_rpc[31:2], 2'b00}; m_cnt = 0; m_wait = 0; pend = 0; exp_valid = 0; exp_err = 0; wait_n = lat;
    end else begin
      if (pend) begin exp_valid = 1; pend = 0; end
      if (p_acc) begin exp_valid = 0; m_pc = m_pc + 32'd4; accepted++; end
      if (p_rd && p_ack) begin
        exp_we = 4'(1 << m_cnt); exp_data = p_data; m_wait = 0; wait_n = lat;
        if (m_cnt == 3) begin m_cnt = 0; pend = 1; end else m_cnt++;
      end else if (p_rd) begin
        m_wait++;
        if (m_wait == 16) exp_err = 1;
      end
    end
    for (int i = 0; i < 4; i++) if (ir_byte_we[i]) tb_ir[8*i +: 8] = ir_data;
    chk("byte_we", ir_byte_we, exp_we);
    if (exp_we != 0) chk("ir_data", ir_data, exp_data);
    chk("inst_pc", inst_pc, m_pc);
    chk("inst_valid", inst_valid, exp_valid);
    chk("fetch_err", fetch_err, exp_err);
    if (mem_rd) chk("mem_addr", mem_addr, m_pc + 32'(m_cnt));
    if (exp_valid || pend || exp_err) chk("mem_rd_quiet", mem_rd, 0);
    if (exp_valid) chk("ir_word", tb_ir, word(m_pc));
    mem_ack = 0;
    if (mem_rd && !no_ack) begin
      if (wait_n == 0) begin mem_ack = 1; mem_rdata = memb(mem_addr); end
      else wait_n--;
    end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
  initial begin
    tv[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 32'h0, 4'h0, 8'h00, 32'h0, 1'b0};
    tv[1]  = '{1'b1, 1'b1, 1'b0, 8'h11, 1'b0, 32'h0, 4'h1, 8'h11, 32'h0, 1'b0};
    tv[2]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 32'h1, 4'h0, 8'h00, 32'h0, 1'b0};
    tv[3]  = '{1'b1, 1'b1, 1'b0, 8'h22, 1'b0, 32'h0, 4'h2, 8'h22, 32'h0, 1'b0};
    tv[4]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 32'h2, 4'h0, 8'h00, 32'h0, 1'b0};
    tv[5]  = '{1'b1, 1'b1, 1'b0, 8'h33, 1'b0, 32'h0, 4'h4, 8'h33, 32'h0, 1'b0};
    tv[6]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 32'h3, 4'h0, 8'h00, 32'h0, 1'b0};
    tv[7]  = '{1'b1, 1'b1, 1'b0, 8'h44, 1'b0, 32'h0, 4'h8, 8'h44, 32'h0, 1'b0};
    tv[8]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0, 4'h0, 8'h00, 32'h0, 1'b1};
    tv[9]  = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 32'h4, 4'h0, 8'h00, 32'h4, 1'b0};
    tv[10] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 32'h4, 4'h0, 8'h00, 32'h4, 1'b0};
    lat = 0;
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 11; i++) begin
      fetch_en = tv[i].fe; mem_ack = tv[i].ack; mem_rdata = tv[i].rd; inst_ready = tv[i].rdy;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d", i),
          {mem_rd, ir_byte_we, (tv[i].xwe != 0) ? ir_data : 8'h0, inst_valid, inst_pc, tv[i].xrd ? mem_addr : 32'h0},
          {tv[i].xrd, tv[i].xwe, tv[i].xd, tv[i].xv, tv[i].xpc, tv[i].xrd ? tv[i].xaddr : 32'h0});
    end
    mem_ack = 0; inst_ready = 0;
    do_reset();
    lat = 3; fetch_en = 1;
    for (int i = 0; i < 60 && !inst_valid; i++) tick();
    chk("slow_valid", inst_valid, 1);
    lat = 0; inst_ready = 1; tick(); inst_ready = 0;
    for (int i = 0; i < 60 && !inst_valid; i++) tick();
    chk("second_valid", inst_valid, 1);
    repeat (10) tick();
    chk("held_valid", {inst_valid, inst_pc}, {1'b1, 32'h4});
    inst_ready = 1; tick(); inst_ready = 0;
    chk("accept_pc", inst_pc, 32'h8);
    for (int i = 0; i < 40 && m_cnt != 2; i++) tick();
    chk("byte1_we", ir_byte_we, 4'b0010);
    redirect_valid = 1; redirect_pc = 32'h0000_1003; tick(); redirect_valid = 0;
    chk("redir_pc", inst_pc, 32'h0000_1000);
    for (int i = 0; i < 10 && !mem_rd; i++) tick();
    chk("redir_addr", {mem_rd, mem_addr}, {1'b1, 32'h0000_1000});
    no_ack = 1; redirect_valid = 1; redirect_pc = 32'h200; tick(); redirect_valid = 0;
    repeat (15) tick();
    chk("err_early", fetch_err, 0);
    tick();
    chk("err_set", {fetch_err, mem_rd}, {1'b1, 1'b0});
    repeat (3) tick();
    chk("err_sticky", {fetch_err, mem_rd}, {1'b1, 1'b0});
    no_ack = 0; redirect_valid = 1; redirect_pc = 32'h40; tick(); redirect_valid = 0;
    chk("err_clear", {fetch_err, mem_rd, mem_addr}, {1'b0, 1'b1, 32'h40});
    for (int i = 0; i < 40 && !inst_valid; i++) tick();
    chk("rr_wait", inst_valid, 1);
    inst_ready = 1; redirect_valid = 1; redirect_pc = 32'h80; tick(); inst_ready = 0; redirect_valid = 0;
    chk("rr_result", {inst_valid, inst_pc}, {1'b0, 32'h80});
    for (int i = 0; i < 40 && m_cnt != 1; i++) tick();
    fetch_en = 0;
    for (int i = 0; i < 40 && !inst_valid; i++) tick();
    chk("fe_low_valid", {inst_valid, inst_pc}, {1'b1, 32'h80});
    inst_ready = 1; tick(); inst_ready = 0;
    rd_seen = 0;
    repeat (6) begin tick(); rd_seen |= mem_rd; end
    chk("fe_low_idle", {rd_seen, inst_pc}, {1'b0, 32'h84});
    accepted = 0;
    for (int c = 0; c < 2000; c++) begin
      lat = $urandom_range(0, 3);
      fetch_en = ($urandom_range(0, 7) != 0);
      inst_ready = ($urandom_range(0, 2) == 0);
      redirect_valid = ($urandom_range(0, 39) == 0);
      redirect_pc = $urandom;
      tick();
    end
    redirect_valid = 0;
    chk("progress", accepted >= 20, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
